// File: rtl/gf2_column_op_scheduler.sv
// gf2_column_op_scheduler: sequences PASS/ADD/SWAP ops for one GF(2) column-elimination pass.
// Define SINGULAR_DETECT_EN to skip FLUSH and flag singular when no pivot is found.
module gf2_column_op_scheduler #(
    parameter int ROWS  = 64,
    parameter int CNT_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             row_valid,
    input  logic             lead_bit,
    output logic             row_ready,
    output logic [1:0]       op_out,
    output logic             op_valid,
    output logic             cell_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pivot_row,
    output logic             singular
);
    typedef enum logic [2:0] {IDLE, CLR, SCAN, FLUSH, DONE} state_t;
    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] pivot_row_q;
    logic             pivot_found_q;
    logic [1:0]       op_q;
    logic             op_valid_q;
    logic             accept;
    logic             last_row;
    logic [1:0]       row_op;
    always_comb begin
        accept   = row_valid && (state_q == SCAN);
        last_row = count_q == CNT_W'(ROWS - 1);
        row_op   = !lead_bit ? OP_PASS : pivot_found_q ? OP_ADD : OP_SWAP;
    end
    assign row_ready = state_q == SCAN;
    assign cell_clr  = state_q == CLR;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign op_out    = op_q;
    assign op_valid  = op_valid_q;
    assign pivot_row = pivot_row_q;
`ifdef SINGULAR_DETECT_EN
    logic singular_q;
    logic pivot_found_d;
    assign pivot_found_d = pivot_found_q || lead_bit;
    assign singular      = singular_q;
`else
    assign singular = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            pivot_row_q   <= '0;
            pivot_found_q <= 1'b0;
            op_q          <= OP_PASS;
            op_valid_q    <= 1'b0;
`ifdef SINGULAR_DETECT_EN
            singular_q    <= 1'b0;
`endif
        end else begin
            op_q       <= OP_PASS;
            op_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start) state_q <= CLR;
                CLR: begin
                    count_q       <= '0;
                    pivot_row_q   <= '0;
                    pivot_found_q <= 1'b0;
`ifdef SINGULAR_DETECT_EN
                    singular_q    <= 1'b0;
`endif
                    state_q       <= SCAN;
                end
                SCAN: if (accept) begin
                    op_q       <= row_op;
                    op_valid_q <= 1'b1;
                    if (lead_bit && !pivot_found_q) begin
                        pivot_found_q <= 1'b1;
                        pivot_row_q   <= count_q;
                    end
                    // the counter parks on the last row; the pass ends instead of wrapping
                    if (last_row) begin
`ifdef SINGULAR_DETECT_EN
                        if (!pivot_found_d) begin
                            singular_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= FLUSH;
                        end
`else
                        state_q <= FLUSH;
`endif
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    op_q       <= OP_SWAP;
                    op_valid_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gf2_column_op_scheduler.sv
// tb_gf2_column_op_scheduler: directed checks of the column-op scheduler with ROWS=4.
module tb_gf2_column_op_scheduler;
    localparam int ROWS = 4;
    localparam int CNT_W = 2;
    localparam logic [1:0] PASS = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] SWAP = 2'b10;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             row_valid = 1'b0;
    logic             lead_bit = 1'b0;
    logic             row_ready;
    logic [1:0]       op_out;
    logic             op_valid;
    logic             cell_clr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pivot_row;
    logic             singular;
    int vectors = 0;
    int miscompares = 0;

    gf2_column_op_scheduler #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .row_valid(row_valid), .lead_bit(lead_bit),
        .row_ready(row_ready), .op_out(op_out), .op_valid(op_valid), .cell_clr(cell_clr),
        .busy(busy), .done(done), .pivot_row(pivot_row), .singular(singular)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_op(input string tag, input logic [1:0] op, input logic v);
        chk({tag, "_op"}, 32'(op_out), 32'(op));
        chk({tag, "_valid"}, 32'(op_valid), 32'(v));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row_ready"}, 32'(row_ready), 0);
        chk_op(tag, PASS, 1'b0);
        chk({tag, "_cell_clr"}, 32'(cell_clr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pivot_row"}, 32'(pivot_row), 0);
        chk({tag, "_singular"}, 32'(singular), 0);
    endtask

    initial begin
        // reset state
        tick;
        tick;
        chk_reset_vals("reset");
        rst = 1'b1;

        // pass 1: lead bits 0,1,1,0 with row_valid held high
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("p1_cell_clr", 32'(cell_clr), 1);
        chk("p1_busy", 32'(busy), 1);
        chk("p1_clr_ready", 32'(row_ready), 0);
        row_valid = 1'b1;
        lead_bit = 1'b0;
        tick;
        chk("p1_cell_clr_off", 32'(cell_clr), 0);
        chk("p1_scan_ready", 32'(row_ready), 1);
        chk_op("p1_clr_noop", PASS, 1'b0);
        tick;
        chk_op("p1_r0", PASS, 1'b1);
        lead_bit = 1'b1;
        tick;
        chk_op("p1_r1", SWAP, 1'b1);
        tick;
        chk_op("p1_r2", ADD, 1'b1);
        lead_bit = 1'b0;
        tick;
        chk_op("p1_r3", PASS, 1'b1);
        chk("p1_flush_ready", 32'(row_ready), 0);
        tick;
        chk_op("p1_flush", SWAP, 1'b1);
        chk("p1_done", 32'(done), 1);
        chk("p1_pivot", 32'(pivot_row), 1);
        chk("p1_singular", 32'(singular), 0);
        row_valid = 1'b0;
        tick;
        chk("p1_done_off", 32'(done), 0);
        chk("p1_idle_busy", 32'(busy), 0);
        chk_op("p1_idle", PASS, 1'b0);
        chk("p1_pivot_hold", 32'(pivot_row), 1);

        // pass 2: lead bits all 1, row_valid toggling 1,0
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        row_valid = 1'b1;
        lead_bit = 1'b1;
        tick;
        chk_op("p2_r0", SWAP, 1'b1);
        row_valid = 1'b0;
        tick;
        chk_op("p2_b0", PASS, 1'b0);
        row_valid = 1'b1;
        tick;
        chk_op("p2_r1", ADD, 1'b1);
        row_valid = 1'b0;
        tick;
        chk_op("p2_b1", PASS, 1'b0);
        row_valid = 1'b1;
        tick;
        chk_op("p2_r2", ADD, 1'b1);
        row_valid = 1'b0;
        tick;
        chk_op("p2_b2", PASS, 1'b0);
        chk("p2_still_scan", 32'(row_ready), 1);
        row_valid = 1'b1;
        tick;
        chk_op("p2_r3", ADD, 1'b1);
        row_valid = 1'b0;
        tick;
        chk_op("p2_flush", SWAP, 1'b1);
        chk("p2_done", 32'(done), 1);
        chk("p2_pivot", 32'(pivot_row), 0);
        tick;
        chk("p2_idle_busy", 32'(busy), 0);

        // pass 3: no pivot in the column
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        row_valid = 1'b1;
        lead_bit = 1'b0;
        tick;
        chk_op("p3_r0", PASS, 1'b1);
        tick;
        chk_op("p3_r1", PASS, 1'b1);
        tick;
        chk_op("p3_r2", PASS, 1'b1);
        tick;
        chk_op("p3_r3", PASS, 1'b1);
        row_valid = 1'b0;
`ifdef SINGULAR_DETECT_EN
        chk("p3_done", 32'(done), 1);
        chk("p3_singular", 32'(singular), 1);
        tick;
        chk_op("p3_no_flush", PASS, 1'b0);
        chk("p3_idle_busy", 32'(busy), 0);
        chk("p3_singular_hold", 32'(singular), 1);
`else
        chk("p3_not_done", 32'(done), 0);
        tick;
        chk_op("p3_flush", SWAP, 1'b1);
        chk("p3_done", 32'(done), 1);
        chk("p3_singular", 32'(singular), 0);
        tick;
        chk("p3_idle_busy", 32'(busy), 0);
`endif

        // pass 4: reset after the second accepted row
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("p4_singular_clr", 32'(singular), 0);
        row_valid = 1'b1;
        lead_bit = 1'b1;
        tick;
        chk_op("p4_r0", SWAP, 1'b1);
        lead_bit = 1'b0;
        tick;
        chk_op("p4_r1", PASS, 1'b1);
        rst = 1'b0;
        lead_bit = 1'b1;
        tick;
        chk_reset_vals("p4_rst");
        rst = 1'b1;
        tick;
        chk_reset_vals("p4_post_rst");

        // pass 5: count restarts at 0, stray starts ignored
        row_valid = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("p5_cell_clr", 32'(cell_clr), 1);
        tick;
        chk("p5_cell_clr_off", 32'(cell_clr), 0);
        row_valid = 1'b1;
        lead_bit = 1'b0;
        tick;
        chk_op("p5_r0", PASS, 1'b1);
        lead_bit = 1'b1;
        tick;
        chk_op("p5_r1", SWAP, 1'b1);
        chk("p5_pivot", 32'(pivot_row), 1);
        start = 1'b1;
        lead_bit = 1'b0;
        tick;
        start = 1'b0;
        chk_op("p5_r2", PASS, 1'b1);
        chk("p5_scan_start_ignored", 32'(cell_clr), 0);
        tick;
        chk_op("p5_r3", PASS, 1'b1);
        row_valid = 1'b0;
        tick;
        chk_op("p5_flush", SWAP, 1'b1);
        chk("p5_done", 32'(done), 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("p5_done_start_busy", 32'(busy), 0);
        chk("p5_done_start_clr", 32'(cell_clr), 0);
        chk("p5_single_done", 32'(done), 0);
        tick;
        chk("p5_stay_idle", 32'(busy), 0);
        chk("p5_pivot_hold", 32'(pivot_row), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gf2_column_op_scheduler.md
GF2_COLUMN_OP_SCHEDULER -- requirements
Module: gf2_column_op_scheduler

Interface
REQ-001 SHALL have parameter ROWS, default 64, meaning rows per elimination pass (ROWS >= 2).
REQ-002 SHALL have parameter CNT_W, default $clog2(ROWS), meaning row counter / pivot index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  begin one pass; sampled only in IDLE.
REQ-006 SHALL have port row_valid  input  1  upstream row present this cycle.
REQ-007 SHALL have port lead_bit  input  1  bit of the current row in the column being eliminated.
REQ-008 SHALL have port row_ready  output  1  scheduler accepts a row; high only in SCAN.
REQ-009 SHALL have port op_out  output  2  op code to the processor_B chain: PASS=2'b00, ADD=2'b01, SWAP=2'b10.
REQ-010 SHALL have port op_valid  output  1  op_out is meaningful this cycle.
REQ-011 SHALL have port cell_clr  output  1  active-high clear for the cell chain's r_reg.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pass-complete pulse.
REQ-014 SHALL have port pivot_row  output  CNT_W  index of the accepted row chosen as pivot.
REQ-015 SHALL have port singular  output  1  no pivot found in the pass; valid while done=1 and held until next start.

Function
REQ-016 SHALL implement FSM states IDLE, CLR, SCAN, FLUSH, DONE.
REQ-017 IDLE with start=1 SHALL go to CLR; start in any other state SHALL be ignored.
REQ-018 CLR SHALL last exactly one cycle with cell_clr=1, clear row count, pivot_found, pivot_row and singular, then go to SCAN.
REQ-019 A row SHALL be accepted on a cycle where row_valid=1 and row_ready=1; row_ready SHALL be combinational from state only.
REQ-020 Per accepted row: if pivot_found=0 and lead_bit=1, op SHALL be SWAP, pivot_found set, pivot_row = current count; else if pivot_found=1 and lead_bit=1, op SHALL be ADD; otherwise PASS.
REQ-021 op_out/op_valid SHALL be registered: latency exactly 1 cycle after acceptance; op_valid=1 for exactly that cycle.
REQ-022 Cycles without acceptance SHALL drive op_out=PASS, op_valid=0 (bubbles allowed, no op emitted).
REQ-023 Row count SHALL increment per acceptance; acceptance of row ROWS-1 SHALL move to FLUSH next cycle with no further rows accepted.
REQ-024 FLUSH SHALL last one cycle and emit op_out=SWAP, op_valid=1 to eject the stored pivot row (subject to REQ-031).
REQ-025 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-026 pivot_row SHALL hold its value from the pivot acceptance until the next CLR.
REQ-027 The row counter SHALL never wrap within a pass; count ROWS-1 is terminal.

Reset
REQ-028 rst=0 at a rising edge SHALL force IDLE regardless of state, including mid-SCAN and FLUSH.
REQ-029 Reset values: row_ready=0, op_out=PASS, op_valid=0, cell_clr=0, busy=0, done=0, pivot_row=0, singular=0, count=0, pivot_found=0.
REQ-030 Rows presented during or in the cycle of reset SHALL not be accepted or produce ops.

Configuration
REQ-031 Macro SINGULAR_DETECT_EN: defined -> if pivot_found=0 at end of SCAN, FLUSH SHALL be skipped (SCAN->DONE) and singular=1 with done; undefined -> singular tied 0 and FLUSH always issues SWAP.

Verification
REQ-032 ROWS=4, lead bits 0,1,1,0, row_valid held high -> ops PASS,SWAP,ADD,PASS each 1 cycle after acceptance, FLUSH SWAP, done, pivot_row=1, singular=0.
REQ-033 ROWS=4, lead bits 1,1,1,1 with row_valid toggling 1,0 -> ops SWAP,ADD,ADD,ADD only on acceptance cycles, op_valid=0 on bubbles, pivot_row=0.
REQ-034 ROWS=4, all lead bits 0, macro defined -> four PASS, no FLUSH op, done with singular=1; macro undefined -> four PASS, FLUSH SWAP, singular=0.
REQ-035 rst=0 after second accepted row -> next cycle IDLE, all outputs at reset values; new start gives cell_clr pulse and count restarts at 0.
REQ-036 start pulsed during SCAN and DONE -> ignored; exactly one done per pass, cell_clr exactly one cycle after start in IDLE.
